// File: rtl/regload_pkg.sv
// Shared types and default sizes for the register bank loader.
// Holds the FSM state enum plus DATA_W/ADDR_W/DEPTH defaults and count width.
package regload_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/regbank_loader_if.sv
// Word stream handshake into the loader: InData/InValid from the source,
// InReady back from the loader. master = source, slave = loader.
interface regbank_loader_if
    import regload_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [DATA_W-1:0] InData;
    logic              InValid;
    logic              InReady;

    modport master (
        output InData,
        output InValid,
        input  InReady
    );

    modport slave (
        input  InData,
        input  InValid,
        output InReady
    );

endinterface

// File: rtl/regload_check.sv
// Readback compare stage: holds the last written addr/data for one cycle,
// drives chk_addr and flags a sticky mismatch against chk_data.
// Ports: clk, rst, clr (Start), wr_en/wr_addr/wr_data, chk_data in;
// chk_addr, mismatch out.
module regload_check
    import regload_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] chk_data,
    output logic [ADDR_W-1:0] chk_addr,
    output logic              mismatch
);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mis_q, mis_d;

    always_comb begin
        vld_d  = wr_en;
        addr_d = addr_q;
        data_d = data_q;
        mis_d  = mis_q;
        if (wr_en) begin
            addr_d = wr_addr;
            data_d = wr_data;
        end
        // Bank was updated at the edge that loaded this stage, so
        // chk_data already reflects the write being verified.
        if (clr) begin
            mis_d = 1'b0;
        end else if (vld_q && (chk_data != data_q)) begin
            mis_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            mis_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
            mis_q  <= mis_d;
        end
    end

    assign chk_addr = addr_q;
    assign mismatch = mis_q;

endmodule

// File: rtl/regbank_loader.sv
// Sequential write-port driver for the register bank: streams words from
// in_if into consecutive addresses starting at BaseAddr (wrapping).
// Ports: clk, rst, Start/BaseAddr/Count, in_if (slave), WriteAddr/Data/RegEn,
// Busy, Done; ChkAddr/ChkData/Mismatch when REGLOAD_READBACK_EN is defined.
module regbank_loader
    import regload_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W:0]   Count,
    regbank_loader_if.slave   in_if,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] Data,
    output logic              RegEn,
`ifdef REGLOAD_READBACK_EN
    output logic [ADDR_W-1:0] ChkAddr,
    input  logic [DATA_W-1:0] ChkData,
    output logic              Mismatch,
`endif
    output logic              Busy,
    output logic              Done
);

    localparam int CW = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              regen_q, regen_d;
    logic [CW-1:0]     cnt_clamp;
    logic              start_acc;
    logic              drain_ok;

    assign cnt_clamp = (Count > CW'(DEPTH)) ? CW'(DEPTH) : Count;
    assign start_acc = Start && (state_q == IDLE);

`ifdef REGLOAD_READBACK_EN
    // Final write retires while RegEn is high; the check stage then
    // compares it on the following edge, so leave once RegEn has dropped.
    assign drain_ok = !regen_q;

    regload_check #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_check (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .wr_en    (regen_q),
        .wr_addr  (waddr_q),
        .wr_data  (data_q),
        .chk_data (ChkData),
        .chk_addr (ChkAddr),
        .mismatch (Mismatch)
    );
`else
    assign drain_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        regen_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    ptr_d   = BaseAddr;
                    rem_d   = cnt_clamp;
                    state_d = (cnt_clamp == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_if.InValid) begin
                    regen_d = 1'b1;
                    data_d  = in_if.InData;
                    waddr_d = ptr_q;
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == CW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_ok) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            waddr_q <= '0;
            data_q  <= '0;
            regen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            regen_q <= regen_d;
        end
    end

    assign in_if.InReady = (state_q == LOAD);
    assign WriteAddr     = waddr_q;
    assign Data          = data_q;
    assign RegEn         = regen_q;
    assign Busy          = (state_q != IDLE);
    assign Done          = (state_q == DONE);

endmodule

// File: tb/tb_regbank_loader.sv
// Self-checking bench for regbank_loader: a behavioural bank plus a
// reference model of expected writes, timing and final bank contents.
module tb_regbank_loader;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = AW + 1;
    localparam int DEP = 32;
`ifdef REGLOAD_READBACK_EN
    localparam int DRAIN_CYC = 2;
`else
    localparam int DRAIN_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Start = 1'b0;
    logic [AW-1:0] BaseAddr = '0;
    logic [CW-1:0] Count = '0;
    logic [AW-1:0] WriteAddr;
    logic [DW-1:0] Data;
    logic          RegEn;
    logic          Busy;
    logic          Done;

    regbank_loader_if #(.DATA_W(DW), .ADDR_W(AW)) in_if ();

    logic [DW-1:0] bank [DEP];
    logic [DW-1:0] ref_bank [DEP];
    int            nwr = 0;

`ifdef REGLOAD_READBACK_EN
    logic [AW-1:0] ChkAddr;
    logic [DW-1:0] ChkData;
    logic          Mismatch;
    logic          corrupt = 1'b0;
    logic [AW-1:0] bad_addr = '0;
    bit            mm_exp = 1'b0;

    assign ChkData = bank[ChkAddr] ^
        ((corrupt && (ChkAddr == bad_addr)) ? {DW{1'b1}} : {DW{1'b0}});
`endif

    regbank_loader dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .BaseAddr  (BaseAddr),
        .Count     (Count),
        .in_if     (in_if),
        .WriteAddr (WriteAddr),
        .Data      (Data),
        .RegEn     (RegEn),
`ifdef REGLOAD_READBACK_EN
        .ChkAddr   (ChkAddr),
        .ChkData   (ChkData),
        .Mismatch  (Mismatch),
`endif
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegEn) begin
            bank[WriteAddr] <= Data;
            nwr <= nwr + 1;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_bank();
        for (int i = 0; i < DEP; i++) begin
            check($sformatf("bank[%0d]", i), 64'(bank[i]), 64'(ref_bank[i]));
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic load(input int base, input int cnt, input int gap_pct,
                        input int vpat_len, input logic [3:0] vpat,
                        input bit fixed, input bit mid_start,
                        input int rst_after, input bit bad2);
        int            n;
        int            k;
        int            cyc;
        int            nwr0;
        int            addr;
        logic          v;
        logic [DW-1:0] w;
        n    = (cnt > DEP) ? DEP : cnt;
        nwr0 = nwr;
        Start    = 1'b1;
        BaseAddr = AW'(base);
        Count    = CW'(cnt);
        in_if.InValid = 1'b0;
        @(negedge clk);
        Start    = 1'b0;
        BaseAddr = AW'($urandom);
        Count    = CW'($urandom);
        check("busy_rise", 64'(Busy), 64'(1));
`ifdef REGLOAD_READBACK_EN
        check("mm_clr", 64'(Mismatch), 64'(0));
        corrupt  = bad2;
        bad_addr = AW'((base + 1) % DEP);
        mm_exp   = bad2 && (n >= 2);
`endif
        if (n == 0) begin
            check("done_zero", 64'(Done), 64'(1));
            check("regen_zero", 64'(RegEn), 64'(0));
            @(negedge clk);
            check("busy_fall0", 64'(Busy), 64'(0));
            check("done_fall0", 64'(Done), 64'(0));
            check("nwr_zero", 64'(nwr - nwr0), 64'(0));
            return;
        end
        check("done_early", 64'(Done), 64'(0));
        k   = 0;
        cyc = 0;
        while (k < n) begin
            check("inready", 64'(in_if.InReady), 64'(1));
            if (cyc < vpat_len) v = vpat[cyc];
            else v = ($urandom_range(99) >= gap_pct);
            w = fixed ? DW'(32'h11 * (k + 1)) : DW'($urandom);
            in_if.InValid = v;
            in_if.InData  = w;
            if (mid_start && cyc == 1) begin
                Start    = 1'b1;
                BaseAddr = AW'(base + 7);
                Count    = CW'(3);
            end
            @(negedge clk);
            Start = 1'b0;
            cyc++;
            if (v) begin
                addr = (base + k) % DEP;
                check("regen_hs", 64'(RegEn), 64'(1));
                check("waddr", 64'(WriteAddr), 64'(addr));
                check("wdata", 64'(Data), 64'(w));
                ref_bank[addr] = w;
                k++;
            end else begin
                check("regen_gap", 64'(RegEn), 64'(0));
            end
            if (v && k == rst_after) begin
                rst = 1'b1;
                in_if.InValid = 1'b0;
                @(negedge clk);
                check("rst_regen", 64'(RegEn), 64'(0));
                check("rst_busy", 64'(Busy), 64'(0));
                check("rst_ready", 64'(in_if.InReady), 64'(0));
                check("rst_done", 64'(Done), 64'(0));
                check("rst_waddr", 64'(WriteAddr), 64'(0));
                check("rst_data", 64'(Data), 64'(0));
`ifdef REGLOAD_READBACK_EN
                check("rst_mm", 64'(Mismatch), 64'(0));
                check("rst_chka", 64'(ChkAddr), 64'(0));
                mm_exp  = 1'b0;
                corrupt = 1'b0;
`endif
                rst = 1'b0;
                check("rst_nwr", 64'(nwr - nwr0), 64'(k));
                check_bank();
                return;
            end
        end
        // Junk presented outside LOAD must not be consumed.
        in_if.InValid = 1'b1;
        in_if.InData  = DW'($urandom);
        check("drain_ready", 64'(in_if.InReady), 64'(0));
        check("drain_done", 64'(Done), 64'(0));
        for (int i = 1; i < DRAIN_CYC; i++) begin
            @(negedge clk);
            check("drain2_done", 64'(Done), 64'(0));
            check("drain2_regen", 64'(RegEn), 64'(0));
        end
        @(negedge clk);
        check("done", 64'(Done), 64'(1));
        check("done_busy", 64'(Busy), 64'(1));
        check("done_regen", 64'(RegEn), 64'(0));
        check("done_ready", 64'(in_if.InReady), 64'(0));
        @(negedge clk);
        in_if.InValid = 1'b0;
        check("post_done", 64'(Done), 64'(0));
        check("post_busy", 64'(Busy), 64'(0));
        check("post_ready", 64'(in_if.InReady), 64'(0));
        check("nwr", 64'(nwr - nwr0), 64'(n));
`ifdef REGLOAD_READBACK_EN
        check("mismatch", 64'(Mismatch), 64'(mm_exp));
        corrupt = 1'b0;
`endif
        check_bank();
    endtask

    initial begin
        in_if.InValid = 1'b0;
        in_if.InData  = '0;
        for (int i = 0; i < DEP; i++) begin
            bank[i]     <= DW'(i) * 32'h0101_0101;
            ref_bank[i]  = DW'(i) * 32'h0101_0101;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst_regen0", 64'(RegEn), 64'(0));
        check("rst_busy0", 64'(Busy), 64'(0));
        check("rst_done0", 64'(Done), 64'(0));
        check("rst_ready0", 64'(in_if.InReady), 64'(0));
        check("rst_waddr0", 64'(WriteAddr), 64'(0));
        check("rst_data0", 64'(Data), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(Busy), 64'(0));

        load(0, 4, 0, 0, 4'b0000, 1'b1, 1'b0, -1, 1'b0);
        load(30, 4, 0, 0, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        load(10, 2, 0, 4, 4'b1001, 1'b0, 1'b1, -1, 1'b0);
        load(5, 0, 0, 0, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        load(0, 8, 0, 0, 4'b0000, 1'b0, 1'b0, 3, 1'b0);
        @(negedge clk);
`ifdef REGLOAD_READBACK_EN
        load(12, 4, 0, 0, 4'b0000, 1'b0, 1'b0, -1, 1'b1);
        @(negedge clk);
        check("mm_sticky", 64'(Mismatch), 64'(1));
        load(20, 3, 0, 0, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
`endif
        load(5, 63, 20, 0, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        load(17, 40, 0, 0, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        for (int r = 0; r < 10; r++) begin
            load(int'($urandom_range(31)), int'($urandom_range(40)),
                 int'($urandom_range(60)), 0, 4'b0000, 1'b0,
                 1'($urandom_range(1)), -1, 1'b0);
            if ($urandom_range(1) == 1) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/regbank_loader.md
# regbank_loader

Sequential write-port driver for the 32x32 register bank. It accepts a stream of 32-bit words on a valid/ready handshake and writes them to consecutive register addresses, starting at a programmable base address. It drives the bank's WriteAddr/Data/RegEn port, which makes it the runtime writer for the bank's combinational read ports. It replaces file-based preloading with a loader usable after reset and during test.

## Interface
- DATA_W, 32, word width
- ADDR_W, 5, register address width
- DEPTH, 32, number of registers (2**ADDR_W)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Start  in  1  one-cycle request to begin a load; ignored while Busy=1
- BaseAddr  in  ADDR_W  first register written; sampled on accepted Start
- Count  in  ADDR_W+1  number of words; sampled on accepted Start; values >DEPTH clamp to DEPTH
- InData  in  DATA_W  word to write
- InValid  in  1  InData valid
- InReady  out  1  loader accepts a word this cycle
- WriteAddr  out  ADDR_W  to bank write address
- Data  out  DATA_W  to bank write data
- RegEn  out  1  to bank write enable
- Busy  out  1  load in progress, from accepted Start through the Done cycle
- Done  out  1  one-cycle completion pulse
- ChkAddr  out  ADDR_W  (REGLOAD_READBACK_EN only) drives a bank read address
- ChkData  in  DATA_W  (REGLOAD_READBACK_EN only) bank read data for ChkAddr
- Mismatch  out  1  (REGLOAD_READBACK_EN only) sticky readback error flag

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: Start=1 captures BaseAddr into ptr and min(Count,DEPTH) into remaining.
  - remaining>0 → LOAD.
  - remaining=0 → DONE directly, with no writes.
- LOAD: InReady=1. A handshake (InValid & InReady) at an edge does all of the following:
  - registers Data<=InData, WriteAddr<=ptr, RegEn<=1;
  - ptr<=ptr+1 mod DEPTH (31 wraps to 0);
  - remaining<=remaining-1.
  - After the last accepted word → DRAIN.
- In LOAD, RegEn falls to 0 the cycle after any cycle with no handshake; InValid gaps are legal.
- DRAIN: InReady=0. Waits until the final RegEn cycle has retired (and the final readback compare, when enabled) → DONE.
- DONE: Done=1 and Busy=1 for exactly one cycle → IDLE.
- InReady is 0 in IDLE, DRAIN and DONE. Words presented outside LOAD are not consumed.
- Start during Busy is ignored. It is not queued.
- rst at any edge, including mid-load:
  - state→IDLE, RegEn=0, InReady=0, Busy=0, Done=0, WriteAddr=0, Data=0, Mismatch=0, ChkAddr=0, ptr=0, remaining=0.
  - Words already written stay in the bank.

## Timing
- Handshake at edge N → RegEn/WriteAddr/Data valid in cycle N..N+1 → bank updated at edge N+1.
- Back-to-back: one word per cycle sustained, with RegEn held high continuously.
- Done rises:
  - without the macro, 2 cycles after the last handshake edge (DRAIN 1 cycle, then DONE);
  - with the macro, 3 cycles after it (DRAIN 2 cycles).
- Count=0: Done asserts the cycle after the Start edge.
- Busy rises the cycle after the accepted Start edge and falls the cycle after Done.

## Configuration
- REGLOAD_READBACK_EN defined:
  - A check stage holds the last written address/data for one cycle and drives ChkAddr=that address.
  - At the following edge it compares ChkData against the held data. If they differ, Mismatch<=1.
  - Mismatch stays set until rst or the next accepted Start.
  - Adds one DRAIN cycle.
- REGLOAD_READBACK_EN undefined: ChkAddr, ChkData and Mismatch ports are absent, and no check logic is built.

## Structure
- Package regload_pkg holds:
  - the state enum (IDLE, LOAD, DRAIN, DONE);
  - DATA_W/ADDR_W/DEPTH defaults;
  - the count width constant.
- One sub-module, regload_check, implements the readback compare pipeline. It is instantiated only under REGLOAD_READBACK_EN.
- The FSM, pointer and counter live in regbank_loader.

## Test plan
- Basic load:
  - Stimulus: Start, BaseAddr=0, Count=4, words 0x11,0x22,0x33,0x44 back-to-back.
  - Response: RegEn high 4 consecutive cycles at addr 0..3; bank reads match; Done 2 cycles after the 4th handshake.
- Wrap:
  - Stimulus: BaseAddr=30, Count=4.
  - Response: writes go to 30,31,0,1 in order.
- Gaps and ignored Start:
  - Stimulus: InValid toggled 1,0,0,1 during Count=2; Start pulsed mid-load.
  - Response: RegEn only in the cycles after handshakes; second Start ignored; exactly 2 writes.
- Zero count:
  - Stimulus: Start with Count=0.
  - Response: no RegEn; Done 1 cycle after Start.
- Reset mid-load:
  - Stimulus: Count=8, rst after 3 handshakes.
  - Response: next cycle RegEn=0, Busy=0, InReady=0; regs 0..2 hold the written values, regs 3..7 unchanged.
- Readback (REGLOAD_READBACK_EN):
  - Stimulus: force ChkData to a wrong value on the 2nd write.
  - Response: Mismatch=1 and stays set after Done; cleared by the next Start.
